switch_debounce_toggle: RTL



---
 rtl/switch_debounce_toggle.sv | 88 ++++++++
 1 files changed

// File: rtl/switch_debounce_toggle.sv
// Per-channel switch debouncer with LED toggle on a selectable debounced edge plus a one-cycle edge strobe.
// Optional build macro SWITCH_DEBOUNCE_SYNC_EN adds a 2-flop input synchronizer, which makes the latency 2 cycles longer.
module switch_debounce_toggle #(
  parameter int NUM_CH         = 4,
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int EDGE_MODE      = 0
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic [NUM_CH-1:0] i_Switch,
  output logic [NUM_CH-1:0] o_LED,
  output logic [NUM_CH-1:0] o_Edge_Pulse,
  output logic [NUM_CH-1:0] o_Switch_Stable
);

  localparam int CW   = $clog2(DEBOUNCE_LIMIT + 1);
  localparam int MODE = (EDGE_MODE == 1 || EDGE_MODE == 2) ? EDGE_MODE : 0;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_LIMIT - 1);

  logic [NUM_CH-1:0] sw_src;
  logic [NUM_CH-1:0] r_switch_q;
  logic [NUM_CH-1:0] stable_q, stable_d;
  logic [NUM_CH-1:0] led_q, led_d;
  logic [NUM_CH-1:0] pulse_q, pulse_d;
  logic [CW-1:0]     cnt_q [NUM_CH];
  logic [CW-1:0]     cnt_d [NUM_CH];

`ifdef SWITCH_DEBOUNCE_SYNC_EN
  logic [NUM_CH-1:0] sync1_q, sync2_q;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= i_Switch;
      sync2_q <= sync1_q;
    end
  end

  assign sw_src = sync2_q;
`else
  assign sw_src = i_Switch;
`endif

  always_comb begin
    stable_d = stable_q;
    led_d    = led_q;
    pulse_d  = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      cnt_d[ch] = cnt_q[ch];
      if (r_switch_q[ch] == stable_q[ch]) begin
        cnt_d[ch] = '0;
      end else if (cnt_q[ch] == CNT_LAST) begin
        cnt_d[ch]    = '0;
        stable_d[ch] = r_switch_q[ch];
        // r_switch_q is the newly accepted level: 1 means a press, 0 a release.
        if ((MODE == 2) || (MODE == 1 && r_switch_q[ch]) || (MODE == 0 && !r_switch_q[ch])) begin
          led_d[ch]   = ~led_q[ch];
          pulse_d[ch] = 1'b1;
        end
      end else begin
        cnt_d[ch] = cnt_q[ch] + CW'(1);
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_switch_q <= '0;
      stable_q   <= '0;
      led_q      <= '0;
      pulse_q    <= '0;
      for (int ch = 0; ch < NUM_CH; ch++) cnt_q[ch] <= '0;
    end else begin
      r_switch_q <= sw_src;
      stable_q   <= stable_d;
      led_q      <= led_d;
      pulse_q    <= pulse_d;
      for (int ch = 0; ch < NUM_CH; ch++) cnt_q[ch] <= cnt_d[ch];
    end
  end

  assign o_LED           = led_q;
  assign o_Edge_Pulse    = pulse_q;
  assign o_Switch_Stable = stable_q;

endmodule
